// File: rtl/calc_pkg.sv
// Shared calculator types: display number format and BCD to 7-segment decode.
package calc_pkg;

    parameter int NumDigits = 8;
    parameter int ExpW      = $clog2(NumDigits);

    // exponent counts fractional digits; significand digit 0 is least significant
    typedef struct packed {
        logic                          sign;
        logic                          error;
        logic [ExpW-1:0]               exponent;
        logic [NumDigits-1:0][3:0]     significand;
    } num_t;

    // Segment order 6=a (top) .. 0=g (middle); codes 10-15 fall through to '9'
    function automatic logic [6:0] bcd2segments(input logic [3:0] bcd);
        logic [6:0] seg;
        case (bcd)
            4'd0:    seg = 7'b1111110;
            4'd1:    seg = 7'b0110000;
            4'd2:    seg = 7'b1101101;
            4'd3:    seg = 7'b1111001;
            4'd4:    seg = 7'b0110011;
            4'd5:    seg = 7'b1011011;
            4'd6:    seg = 7'b1011111;
            4'd7:    seg = 7'b1110000;
            4'd8:    seg = 7'b1111111;
            default: seg = 7'b1111011;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/calc_display_scan_if.sv
// Display scanner bus: value/blank in from the calculator core, scan drive out to the LEDs.
interface calc_display_scan_if #(
    parameter int NumDigits = calc_pkg::NumDigits
);
    calc_pkg::num_t         num_i;
    logic                   blank_i;
    logic [NumDigits-1:0]   digit_sel_o;
    logic [6:0]             segments_o;
    logic                   dp_o;
    logic                   minus_o;
    logic                   error_o;
    logic                   frame_o;

    modport master (
        output num_i, blank_i,
        input  digit_sel_o, segments_o, dp_o, minus_o, error_o, frame_o
    );

    modport slave (
        input  num_i, blank_i,
        output digit_sel_o, segments_o, dp_o, minus_o, error_o, frame_o
    );
endinterface

// File: rtl/calc_display_scan.sv
// Multiplexed 7-segment scanner: latches the number once per frame and drives one
// digit at a time with leading-zero blanking, decimal point and annunciators.
module calc_display_scan #(
    parameter int NumDigits = calc_pkg::NumDigits,
    parameter int ScanDiv   = 1000
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    calc_display_scan_if.slave bus
);

    localparam int         CntW = (ScanDiv > 1) ? $clog2(ScanDiv) : 1;
    localparam int         IdxW = (NumDigits > 1) ? $clog2(NumDigits) : 1;
    localparam logic [6:0] SegE = 7'b1001111;

    logic [CntW-1:0]      cnt_q, cnt_d;
    logic [IdxW-1:0]      idx_q, idx_d;
    calc_pkg::num_t       shd_q, shd_d;
    logic                 frame_start;
    logic [IdxW-1:0]      top;

    logic [NumDigits-1:0] sel_q, sel_d;
    logic [6:0]           seg_q, seg_d;
    logic                 dp_q, dp_d;
    logic                 minus_q, minus_d;
    logic                 err_q, err_d;
    logic                 frame_q, frame_d;

    always_comb begin
        cnt_d = (cnt_q == CntW'(ScanDiv - 1)) ? '0 : cnt_q + 1'b1;
        idx_d = idx_q;
        if (cnt_q == CntW'(ScanDiv - 1)) begin
            idx_d = (idx_q == IdxW'(NumDigits - 1)) ? '0 : idx_q + 1'b1;
        end
        frame_start = (cnt_q == '0) && (idx_q == '0);
        shd_d       = frame_start ? bus.num_i : shd_q;
    end

    // Highest digit worth showing: top nonzero digit, but never below the decimal point
    always_comb begin
        top = IdxW'(shd_q.exponent);
        for (int i = 0; i < NumDigits; i++) begin
            if (shd_q.significand[i] != 4'd0 && IdxW'(i) > top) top = IdxW'(i);
        end
    end

    always_comb begin
        sel_d   = '0;
        seg_d   = '0;
        dp_d    = 1'b0;
        minus_d = 1'b0;
        err_d   = 1'b0;
        // Digit 0 is first shown with the old shadow; the frame marker waits for the fresh one
        frame_d = (cnt_q == CntW'(1)) && (idx_q == '0);
        if (!bus.blank_i) begin
            sel_d[idx_q] = 1'b1;
            if (shd_q.error) begin
                err_d = 1'b1;
                if (idx_q == '0) seg_d = SegE;
            end else begin
                minus_d = shd_q.sign && (shd_q.significand != '0);
                if (idx_q <= top) seg_d = calc_pkg::bcd2segments(shd_q.significand[idx_q]);
                dp_d = (shd_q.exponent != '0) && (IdxW'(shd_q.exponent) == idx_q);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q   <= '0;
            idx_q   <= '0;
            shd_q   <= '0;
            sel_q   <= '0;
            seg_q   <= '0;
            dp_q    <= 1'b0;
            minus_q <= 1'b0;
            err_q   <= 1'b0;
            frame_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shd_q   <= shd_d;
            sel_q   <= sel_d;
            seg_q   <= seg_d;
            dp_q    <= dp_d;
            minus_q <= minus_d;
            err_q   <= err_d;
            frame_q <= frame_d;
        end
    end

    assign bus.digit_sel_o = sel_q;
    assign bus.segments_o  = seg_q;
    assign bus.dp_o        = dp_q;
    assign bus.minus_o     = minus_q;
    assign bus.error_o     = err_q;
    assign bus.frame_o     = frame_q;

endmodule

// File: tb/tb_calc_display_scan.sv
// Bench for calc_display_scan (8 digits, 4 cycles per digit): frame-level model plus
// directed literal checks of whole frames, blanking, mid-frame updates and reset.
module tb_calc_display_scan;

    localparam int ND = 8;
    localparam int SD = 4;
    localparam int FR = ND * SD;

    localparam logic [6:0] SEG [16] = '{
        7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
        7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
        7'b1111111, 7'b1111011, 7'b1111011, 7'b1111011,
        7'b1111011, 7'b1111011, 7'b1111011, 7'b1111011
    };

    logic clk;
    logic rst_n;
    int   asserts = 0;
    int   fails   = 0;

    calc_display_scan_if #(.NumDigits(ND)) bus ();

    calc_display_scan #(.NumDigits(ND), .ScanDiv(SD)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        asserts++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic calc_pkg::num_t mk(input logic s, input logic e, input logic [2:0] ex,
                                          input logic [31:0] sig);
        calc_pkg::num_t r;
        r.sign        = s;
        r.error       = e;
        r.exponent    = ex;
        r.significand = sig;
        return r;
    endfunction

    // What the display must show for digit idx of a latched number
    function automatic void model(input int idx, input calc_pkg::num_t s, input logic bl,
                                  output logic [7:0] sel, output logic [6:0] seg,
                                  output logic dp, output logic mi, output logic er);
        logic [31:0] sig;
        sig = s.significand;
        sel = '0; seg = '0; dp = 1'b0; mi = 1'b0; er = 1'b0;
        if (bl) return;
        sel = 8'h01 << idx;
        if (s.error) begin
            er = 1'b1;
            if (idx == 0) seg = 7'b1001111;
            return;
        end
        mi = s.sign && (sig != 0);
        if (idx == 0 || idx <= int'(s.exponent) || (sig >> (4 * idx)) != 0)
            seg = SEG[sig[4*idx +: 4]];
        dp = (s.exponent != 0) && (idx == int'(s.exponent));
    endfunction

    // Model: k = edges since reset release; shadow = number latched at the last frame start
    int             k;
    calc_pkg::num_t shd_m;
    logic [7:0]     esel;
    logic [6:0]     eseg;
    logic           edp, emi, eer, efr;

    always @(posedge clk) begin
        if (!rst_n) begin
            k = 0; shd_m = '0;
            esel = '0; eseg = '0; edp = 1'b0; emi = 1'b0; eer = 1'b0; efr = 1'b0;
        end else begin
            model((k / SD) % ND, shd_m, bus.blank_i, esel, eseg, edp, emi, eer);
            efr = ((k % FR) == 1);
            if ((k % FR) == 0) shd_m = bus.num_i;
            k++;
        end
        #1;
        check("m_sel",   32'(bus.digit_sel_o), 32'(esel));
        check("m_seg",   32'(bus.segments_o),  32'(eseg));
        check("m_dp",    32'(bus.dp_o),        32'(edp));
        check("m_minus", 32'(bus.minus_o),     32'(emi));
        check("m_error", 32'(bus.error_o),     32'(eer));
        check("m_frame", 32'(bus.frame_o),     32'(efr));
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_num(input calc_pkg::num_t v);
        @(negedge clk);
        bus.num_i = v;
    endtask

    task automatic go_frame();
        bit seen;
        seen = 1'b0;
        for (int c = 0; c < FR + 8 && !seen; c++) begin
            step(1);
            if (bus.frame_o) seen = 1'b1;
        end
        check("frame_wait", 32'(seen), 32'd1);
    endtask

    // Walk one frame from frame_o, checking every digit against literal expectations
    task automatic check_frame(input string name, input logic [7:0][6:0] segs, input int dpd,
                               input logic mi, input logic er);
        for (int d = 0; d < ND; d++) begin
            check({name, "_sel"},   32'(bus.digit_sel_o), 32'(8'h01 << d));
            check({name, "_seg"},   32'(bus.segments_o),  32'(segs[d]));
            check({name, "_dp"},    32'(bus.dp_o),        32'(d == dpd));
            check({name, "_minus"}, 32'(bus.minus_o),     32'(mi));
            check({name, "_error"}, 32'(bus.error_o),     32'(er));
            if (d < ND - 1) step(SD);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        bus.num_i = '0;
        bus.blank_i = 1'b0;
        step(3);
        check("rst_sel",   32'(bus.digit_sel_o), 32'd0);
        check("rst_seg",   32'(bus.segments_o),  32'd0);
        check("rst_frame", 32'(bus.frame_o),     32'd0);
        check("rst_dp_mi_er", 32'({bus.dp_o, bus.minus_o, bus.error_o}), 32'd0);

        @(negedge clk) rst_n = 1'b1;
        step(1);
        check("e0_sel",   32'(bus.digit_sel_o), 32'h01);
        check("e0_frame", 32'(bus.frame_o),     32'd0);
        step(1);
        check("e1_frame", 32'(bus.frame_o),     32'd1);
        check("e1_sel",   32'(bus.digit_sel_o), 32'h01);
        check("e1_seg",   32'(bus.segments_o),  32'h7E);
        step(3);
        check("e4_sel",   32'(bus.digit_sel_o), 32'h02);
        check("e4_seg",   32'(bus.segments_o),  32'd0);

        set_num(mk(1'b0, 1'b0, 3'd0, 32'h123));
        go_frame();
        check_frame("p123", {7'd0, 7'd0, 7'd0, 7'd0, 7'd0, 7'b0110000, 7'b1101101, 7'b1111001},
                    -1, 1'b0, 1'b0);

        set_num(mk(1'b1, 1'b0, 3'd2, 32'h5));
        go_frame();
        check_frame("m005", {7'd0, 7'd0, 7'd0, 7'd0, 7'd0, 7'b1111110, 7'b1111110, 7'b1011011},
                    2, 1'b1, 1'b0);

        set_num(mk(1'b1, 1'b1, 3'd0, 32'h123));
        go_frame();
        check_frame("err", {7'd0, 7'd0, 7'd0, 7'd0, 7'd0, 7'd0, 7'd0, 7'b1001111},
                    -1, 1'b0, 1'b1);

        // Change the number while digit 3 of a 123 frame is on screen
        set_num(mk(1'b0, 1'b0, 3'd0, 32'h123));
        go_frame();
        step(12);
        set_num(mk(1'b0, 1'b0, 3'd0, 32'h456));
        step(1);
        check("mid_sel3", 32'(bus.digit_sel_o), 32'h08);
        check("mid_seg3", 32'(bus.segments_o),  32'd0);
        go_frame();
        check_frame("p456", {7'd0, 7'd0, 7'd0, 7'd0, 7'd0, 7'b0110011, 7'b1011011, 7'b1011111},
                    -1, 1'b0, 1'b0);

        // Blank for 6 edges in the middle of digit 1
        go_frame();
        step(5);
        @(negedge clk) bus.blank_i = 1'b1;
        step(1);
        check("blk_sel", 32'(bus.digit_sel_o), 32'd0);
        check("blk_seg", 32'(bus.segments_o),  32'd0);
        check("blk_frame", 32'(bus.frame_o),   32'd0);
        step(5);
        @(negedge clk) bus.blank_i = 1'b0;
        step(1);
        check("unblk_sel", 32'(bus.digit_sel_o), 32'h08);
        check("unblk_seg", 32'(bus.segments_o),  32'd0);

        set_num(mk(1'b0, 1'b0, 3'd3, 32'hA));
        go_frame();
        check_frame("nonbcd", {7'd0, 7'd0, 7'd0, 7'd0, 7'b1111110, 7'b1111110, 7'b1111110, 7'b1111011},
                    3, 1'b0, 1'b0);

        set_num(mk(1'b1, 1'b0, 3'd0, 32'h0));
        go_frame();
        check_frame("negzero", {7'd0, 7'd0, 7'd0, 7'd0, 7'd0, 7'd0, 7'd0, 7'b1111110},
                    -1, 1'b0, 1'b0);

        // Asynchronous reset in the middle of a frame
        set_num(mk(1'b1, 1'b0, 3'd0, 32'h78));
        go_frame();
        step(10);
        @(negedge clk) rst_n = 1'b0;
        #1;
        check("arst_sel", 32'(bus.digit_sel_o), 32'd0);
        check("arst_seg", 32'(bus.segments_o),  32'd0);
        check("arst_mi",  32'(bus.minus_o),     32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        step(1);
        check("rel_seg0", 32'(bus.segments_o), 32'h7E);
        check("rel_mi0",  32'(bus.minus_o),    32'd0);
        step(1);
        check("rel_frame", 32'(bus.frame_o),    32'd1);
        check("rel_seg",   32'(bus.segments_o), 32'(7'b1111111));
        check("rel_mi",    32'(bus.minus_o),    32'd1);
        step(4);

        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d failures so far", fails);
        $fatal(1);
    end

endmodule
